// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

   localparam int   DATA_W   = 8;
   localparam logic STOP_LVL = 1'b1;

endpackage

// File: rtl/uart_rx_byte_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; the reset level is
// a parameter so idle-high and idle-low lines can both reuse it.
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         r_meta <= RST_VAL;
         r_sync <= RST_VAL;
      end else begin
         // NOTE: non-blocking so the two flops shift on the same edge instead of collapsing into one.
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 serial receiver: mid-bit sampling from a half-bit start alignment,
// one-cycle valid / frame_err pulses, data_out holds the last good byte.
module uart_rx_byte #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_W       = uart_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              rst_,
   input  logic              rx,
   output logic [DATA_W-1:0] data_out,
   output logic              valid,
   output logic              frame_err,
   output logic              busy
);

   import uart_pkg::*;

   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_W);
   localparam logic [TW-1:0] TICK_HALF = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0] TICK_FULL = TW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);

   logic              w_rx_s;
   rx_state_t         r_state;
   rx_state_t         w_state_nxt;
   logic [TW-1:0]     r_tick;
   logic [BW-1:0]     r_bit;
   logic [DATA_W-1:0] r_shift;
   logic [DATA_W-1:0] r_data;
   logic              r_valid;
   logic              r_ferr;
   logic              r_busy;
   logic              w_tick_half;
   logic              w_tick_full;
   logic              w_shift_en;
   logic              w_valid_nxt;
   logic              w_ferr_nxt;

   sync_2ff #(.RST_VAL(1'b1)) u_rx_sync (
      .clk  (clk),
      .rst_ (rst_),
      .i_d  (rx),
      .o_q  (w_rx_s)
   );

   assign w_tick_half = (r_tick == TICK_HALF);
   assign w_tick_full = (r_tick == TICK_FULL);

   // State register plus the datapath counters it sequences.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         r_state <= IDLE;
         r_tick  <= '0;
         r_bit   <= '0;
         r_shift <= '0;
      end else begin
         r_state <= w_state_nxt;
         if ((w_state_nxt != r_state) || (r_state == IDLE)) r_tick <= '0;
         else                                                r_tick <= r_tick + 1'b1;
         if (r_state == START)  r_bit <= '0;
         else if (w_shift_en)   r_bit <= r_bit + 1'b1;
         if (w_shift_en) r_shift <= {w_rx_s, r_shift[DATA_W-1:1]};
      end
   end

   always_comb begin
      // NOTE: default first so every path assigns and no latch is inferred.
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:    if (!w_rx_s) w_state_nxt = START;
         START:   if (w_tick_half) w_state_nxt = w_rx_s ? IDLE : DATA;
         DATA:    if (w_tick_full && (r_bit == LAST_BIT)) w_state_nxt = STOP;
         STOP:    if (w_tick_full) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_shift_en  = (r_state == DATA) && w_tick_full;
      w_valid_nxt = (r_state == STOP) && w_tick_full && (w_rx_s == STOP_LVL);
      w_ferr_nxt  = (r_state == STOP) && w_tick_full && (w_rx_s != STOP_LVL);
   end

   // Registered outputs; busy trails the state by one cycle.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         r_data  <= '0;
         r_valid <= 1'b0;
         r_ferr  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_valid <= w_valid_nxt;
         r_ferr  <= w_ferr_nxt;
         r_busy  <= (r_state != IDLE);
         if (w_valid_nxt) r_data <= r_shift;
      end
   end

   assign data_out  = r_data;
   assign valid     = r_valid;
   assign frame_err = r_ferr;
   assign busy      = r_busy;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed and random frames against a frame-level model of the receiver.
module tb_uart_rx_byte;

   localparam int C = 4;

   logic       clk  = 1'b0;
   logic       rst_ = 1'b0;
   logic       rx   = 1'b1;
   logic [7:0] data_out;
   logic       valid;
   logic       frame_err;
   logic       busy;

   uart_rx_byte #(.CLKS_PER_BIT(C)) dut (
      .clk       (clk),
      .rst_      (rst_),
      .rx        (rx),
      .data_out  (data_out),
      .valid     (valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Downstream enable register fed by valid / data_out.
   logic [7:0] cap_q = 8'h00;
   always @(posedge clk) if (valid) cap_q <= data_out;

   typedef struct {
      bit          err;
      logic [7:0]  data;
      int unsigned stamp;
   } ev_t;

   typedef struct {
      bit         err;
      logic [7:0] data;
   } exp_t;

   ev_t  obs_q[$];
   exp_t exp_q[$];
   logic [7:0] last_good = 8'h00;

   int   viol       = 0;
   logic prev_valid = 1'b0;
   logic prev_ferr  = 1'b0;
   logic [7:0] prev_data = 8'h00;

   // Pulse monitor: records events and counts protocol rule breaks.
   always @(negedge clk) begin
      if (rst_) begin
         if (valid)     obs_q.push_back('{err: 1'b0, data: data_out, stamp: cyc});
         if (frame_err) obs_q.push_back('{err: 1'b1, data: data_out, stamp: cyc});
         if (valid && frame_err) viol++;
         if ((valid && prev_valid) || (frame_err && prev_ferr)) viol++;
         if (!valid && (data_out !== prev_data)) viol++;
      end
      prev_valid = valid;
      prev_ferr  = frame_err;
      prev_data  = data_out;
   end

   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_bits(input int n);
      rx = 1'b1;
      repeat (n * C) @(negedge clk);
   endtask

   // Drives one frame from a negedge; start_cyc is the first edge that sees rx low.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int unsigned start_cyc);
      rx = 1'b0;
      start_cyc = cyc + 1;
      repeat (C) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (C) @(negedge clk);
      end
      rx = stop_bit;
      repeat (C) @(negedge clk);
      rx = 1'b1;
      if (stop_bit) begin
         exp_q.push_back('{err: 1'b0, data: b});
         last_good = b;
      end else begin
         exp_q.push_back('{err: 1'b1, data: last_good});
      end
   endtask

   task automatic compare_events(input string tag);
      #1;
      check({tag, " event count"}, 32'(obs_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         check($sformatf("%s ev%0d kind", tag, i), 32'(obs_q[i].err),  32'(exp_q[i].err));
         check($sformatf("%s ev%0d data", tag, i), 32'(obs_q[i].data), 32'(exp_q[i].data));
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned t0, t1;
      logic [7:0]  d0;
      logic        busy_seen;
      logic [7:0]  rb;
      logic        rerr;

      // Reset held with the line toggling.
      rst_ = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         rx = ~rx;
      end
      #1;
      check("reset data_out",  32'(data_out),  32'h00);
      check("reset valid",     32'(valid),     32'h0);
      check("reset frame_err", 32'(frame_err), 32'h0);
      check("reset busy",      32'(busy),      32'h0);
      @(negedge clk);
      rx   = 1'b1;
      rst_ = 1'b1;
      idle_bits(3);
      #1;
      check("post-reset busy",     32'(busy),         32'h0);
      check("post-reset data_out", 32'(data_out),     32'h00);
      check("post-reset events",   32'(obs_q.size()), 32'h0);

      // 0xA5: latency, pulse shape and downstream capture.
      @(negedge clk);
      send_frame(8'hA5, 1'b1, t0);
      @(negedge clk); #1;
      check("A5 valid high",    32'(valid),    32'h1);
      check("A5 busy at valid", 32'(busy),     32'h1);
      check("A5 data_out",      32'(data_out), 32'hA5);
      @(negedge clk); #1;
      check("A5 valid low",     32'(valid),    32'h0);
      check("A5 busy fell",     32'(busy),     32'h0);
      check("A5 captured",      32'(cap_q),    32'hA5);
      if (obs_q.size() > 0) check("A5 latency", obs_q[0].stamp - t0, 32'd40);
      idle_bits(2);
      compare_events("A5");

      // One-cycle glitch is rejected as a false start.
      d0 = data_out;
      @(negedge clk);
      rx = 1'b0;
      @(negedge clk);
      rx = 1'b1;
      busy_seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #1;
         busy_seen |= busy;
      end
      check("glitch busy pulsed", 32'(busy_seen),    32'h1);
      check("glitch busy idle",   32'(busy),         32'h0);
      check("glitch no events",   32'(obs_q.size()), 32'h0);
      check("glitch data_out",    32'(data_out),     32'(d0));

      // Good 0x81 then 0x3C with a low stop bit.
      @(negedge clk);
      send_frame(8'h81, 1'b1, t0);
      idle_bits(2);
      send_frame(8'h3C, 1'b0, t0);
      idle_bits(3);
      compare_events("stop-err");
      check("stop-err data_out", 32'(data_out), 32'h81);

      // Back-to-back 0x00 / 0xFF with no idle gap.
      send_frame(8'h00, 1'b1, t0);
      send_frame(8'hFF, 1'b1, t1);
      idle_bits(2);
      #1;
      if (obs_q.size() >= 2) check("b2b spacing", obs_q[1].stamp - obs_q[0].stamp, 32'd40);
      compare_events("b2b");
      check("b2b data_out", 32'(data_out), 32'hFF);

      // Reset during bit 4 of 0x5A, then 0x96.
      rx = 1'b0;
      repeat (C) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rx = rb_bit(8'h5A, i);
         repeat (C) @(negedge clk);
      end
      rx = 1'b1;
      repeat (2) @(negedge clk);
      rst_ = 1'b0;
      last_good = 8'h00;
      repeat (3) @(negedge clk);
      #1;
      check("abort busy in reset", 32'(busy), 32'h0);
      @(negedge clk);
      rst_ = 1'b1;
      idle_bits(2);
      #1;
      check("abort no events", 32'(obs_q.size()), 32'h0);
      check("abort data_out",  32'(data_out),     32'h00);
      @(negedge clk);
      send_frame(8'h96, 1'b1, t0);
      idle_bits(2);
      compare_events("after-abort");
      check("after-abort data_out", 32'(data_out), 32'h96);

      // Random frames, some with a low stop bit and variable idle gaps.
      for (int n = 0; n < 12; n++) begin
         rb   = 8'($urandom_range(0, 255));
         rerr = ($urandom_range(0, 3) == 0);
         send_frame(rb, !rerr, t0);
         idle_bits(rerr ? 1 + int'($urandom_range(0, 1)) : int'($urandom_range(0, 2)));
      end
      idle_bits(2);
      compare_events("random");
      check("random data_out", 32'(data_out), 32'(last_good));
      check("pulse rule violations", 32'(viol), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   function automatic logic rb_bit(input logic [7:0] b, input int i);
      return b[i];
   endfunction

endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
- Serial-to-parallel receive stage that feeds the team's 8-bit enable register.
- Decodes 8N1 asynchronous serial frames on a single input line.
- Presents each received byte on data_out with a one-cycle valid pulse; valid connects directly to the register's enable and data_out to its data input.
- Flags bad stop bits with frame_err.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; legal range >= 4.
- DATA_W, 8, payload bits per frame; fixed at 8 for this release.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_  input  1  asynchronous active-low reset.
- rx  input  1  serial line; idle high; asynchronous to clk.
- data_out  output  DATA_W  last good received byte.
- valid  output  1  one-cycle pulse: data_out updated this cycle.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- busy  output  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Reset (async, rst_ low), all cleared immediately:
  - data_out=0, valid=0, frame_err=0, busy=0.
  - Synchronizer flops=1, state=IDLE, bit counter=0, tick counter=0, shift register=0.
- Input sync: rx passes through 2 flops to give rx_s; the FSM only sees rx_s.
- Tick counter: width $clog2(CLKS_PER_BIT); cleared on every state transition.
- FSM states:
  - IDLE: when rx_s==0, go to START.
  - START: at tick==CLKS_PER_BIT/2-1 (integer divide), sample rx_s.
    - rx_s==0: go to DATA with bit counter=0.
    - rx_s==1: false start; return to IDLE with no outputs.
  - DATA: at tick==CLKS_PER_BIT-1, sample rx_s into the shift register, LSB first (shift right, insert at MSB).
    - After bit 7: go to STOP.
    - Otherwise: increment the bit counter.
  - STOP: at tick==CLKS_PER_BIT-1, sample rx_s and return to IDLE.
    - rx_s==1: data_out<=shift register and valid=1 for exactly that cycle.
    - rx_s==0: frame_err=1 for that cycle; data_out holds its previous value; valid stays 0.
- Sampling points are mid-bit. The START half-bit alignment puts every later sample at bit centre.
- Latency: valid rises (2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT) clk cycles after rx falls at the start edge. With CLKS_PER_BIT=4: 40 cycles.
- Back-to-back frames: after STOP the FSM is in IDLE the next cycle, so a start bit immediately following the stop bit is accepted.
- rx held low after a frame error: IDLE sees rx_s==0 and starts a new frame (break is not special-cased).
- valid and frame_err are never high in the same cycle. Neither is ever high for more than 1 cycle.
- Outside valid pulses, data_out changes only on reset.
- Reset asserted mid-frame: the frame is abandoned with no pulse. After release, the FSM waits in IDLE for the next falling edge.

Decomposition:
- Shared package uart_pkg holds:
  - typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t
  - localparam DATA_W=8
  - localparam STOP_LVL=1'b1
- One natural sub-module: sync_2ff, the 2-flop synchronizer. Its reset value is a parameter (1 here); it is reusable by future async inputs.
- Tick counter and FSM stay inline.

Test Plan (CLKS_PER_BIT=4, bit time = 4 clk):
- Reset: hold rst_=0 with rx toggling -> data_out=0x00, valid=0, frame_err=0, busy=0. Release -> all hold until the first start bit.
- Send 0xA5 (line sequence 0,1,0,1,0,0,1,0,1,1) -> exactly one valid pulse, 40 cycles after the start edge. data_out=0xA5; a downstream register captures 0xA5. busy falls the cycle after valid.
- Glitch: rx low for 1 clk then high -> busy pulses, no valid, no frame_err, FSM back in IDLE, data_out unchanged.
- Stop bit forced 0 while sending 0x3C after a good 0x81 -> frame_err one-cycle pulse, valid=0, data_out stays 0x81.
- Back-to-back 0x00 then 0xFF with no idle gap -> two valid pulses 40 cycles apart, data_out=0x00 then 0xFF.
- Assert rst_ during bit 4 of 0x5A, release, then send 0x96 -> no pulse for the aborted frame; exactly one valid with data_out=0x96.
